// File: rtl/ram_ctrl_pkg.sv
// Shared types for the burst front end of the 256x64 single-port ram.
package ram_ctrl_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 64;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN} state_e;

  typedef struct packed {
    logic              write;
    logic [AW_DEF-1:0] addr;
    logic [LEN_W-1:0]  len;
  } cmd_t;
endpackage

// File: rtl/ctrl_rd_fifo.sv
// Small synchronous FIFO holding read beats returned by the ram.
module ctrl_rd_fifo #(
  parameter int DW         = 64,
  parameter int FIFO_DEPTH = 2,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rp_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= ptr_inc(wp_q);
      if (do_pop)  rp_q <= ptr_inc(rp_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: count/pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end
endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst command front end: one ram access per cycle, read latency absorbed
// by an in-flight tracker plus a small return FIFO.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DW-1:0]    wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [DW-1:0]    rd_data,
  output logic             busy,
  output logic             ram_cen,
  output logic             ram_wen,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_din,
  input  logic [DW-1:0]    ram_dout
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     cur_q, cur_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [RD_LAT-1:0] infl_q;
  logic              busy_q, cmd_rdy_q, wr_rdy_q;
  cmd_t              cmd_in;

  logic              wr_hs, rd_issue, rd_hs, push;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [DW-1:0]     fifo_dout;
  logic [CW-1:0]     fifo_cnt;
  int unsigned       occ;

  assign cmd_in    = '{write: cmd_write, addr: cmd_addr, len: cmd_len};
  assign cmd_ready = cmd_rdy_q;
  assign wr_ready  = wr_rdy_q;
  assign busy      = busy_q;
  assign wr_hs     = wr_rdy_q & wr_valid;

  // An empty FIFO is bypassed so a returning beat is visible the cycle
  // ram_dout becomes valid; it is only stored if the consumer stalls.
  assign push      = infl_q[RD_LAT-1];
  assign rd_valid  = ~fifo_empty | push;
  assign rd_data   = !fifo_empty ? fifo_dout : (push ? ram_dout : '0);
  assign rd_hs     = rd_valid & rd_ready;
  assign fifo_pop  = ~fifo_empty & rd_ready;
  assign fifo_push = push & ~fifo_full & ~(fifo_empty & rd_ready);

  // A beat being consumed this cycle frees its slot for a new issue.
  always_comb begin
    occ      = 32'(fifo_cnt) + 32'($countones(infl_q));
    rd_issue = (state_q == ST_READ) && (occ < 32'(FIFO_DEPTH) + 32'(rd_hs));
  end

  assign ram_cen  = wr_hs | rd_issue;
  assign ram_wen  = wr_hs;
  assign ram_addr = ram_cen ? cur_q : '0;
  assign ram_din  = wr_hs ? wr_data : '0;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid) begin
        cur_d   = cmd_in.addr;
        rem_d   = cmd_in.len;
        state_d = cmd_in.write ? ST_WRITE : ST_READ;
      end
      ST_WRITE: if (wr_hs) begin
        cur_d = cur_q + AW'(1);
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == '0) state_d = ST_IDLE;
      end
      ST_READ: if (rd_issue) begin
        cur_d = cur_q + AW'(1);
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (infl_q == '0 && fifo_empty) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      cmd_rdy_q <= 1'b1;
      wr_rdy_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      rem_q     <= rem_d;
      busy_q    <= (state_d != ST_IDLE);
      cmd_rdy_q <= (state_d == ST_IDLE);
      wr_rdy_q  <= (state_d == ST_WRITE);
    end
  end

  // One bit per outstanding read; the top bit marks ram_dout valid now.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) infl_q <= '0;
    else          infl_q <= (infl_q << 1) | RD_LAT'(rd_issue);
  end

  ctrl_rd_fifo #(
    .DW        (DW),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CW        (CW)
  ) u_rd_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (ram_dout),
    .dout   (fifo_dout),
    .count  (fifo_cnt),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 256x64 ram behind it.
module tb_ram_burst_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0, cmd_len = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [63:0] wr_data = '0;
  logic        rd_valid, rd_ready = 1'b0;
  logic [63:0] rd_data;
  logic        busy, ram_cen, ram_wen;
  logic [7:0]  ram_addr;
  logic [63:0] ram_din, ram_dout;
  logic [63:0] mem [256];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cen) begin
      if (ram_wen) mem[ram_addr] <= ram_din;
      else         ram_dout      <= mem[ram_addr];
    end
  end

  ram_burst_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .ram_cen(ram_cen), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat k carries base+k to address a+k (mod 256). stall toggles wr_valid,
  // poke offers a read command during beat 1.
  task automatic wr_burst(input logic [7:0] a, input logic [7:0] len, input logic [63:0] base,
                          input bit stall, input bit poke, input string tag);
    int beat = 0, n = 0, bad = 0;
    bit tog = 1'b1;
    logic [7:0] exp_a;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
    while (beat <= int'(len) && n < 1000) begin
      wr_valid = stall ? tog : 1'b1;
      wr_data  = base + 64'(beat);
      if (poke && beat == 1) begin
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h99;
      end else cmd_valid = 1'b0;
      #2;
      if (poke && beat == 1) chk({tag, "_cmd_ready"}, cmd_ready, 0);
      exp_a = a + 8'(beat);
      if (wr_valid && wr_ready) begin
        if (ram_cen !== 1'b1 || ram_wen !== 1'b1 || ram_addr !== exp_a || ram_din !== wr_data) bad++;
        beat++;
      end else if (ram_cen !== 1'b0) bad++;
      tog = !tog;
      n++;
      tick();
    end
    wr_valid = 1'b0; cmd_valid = 1'b0;
    #2;
    chk({tag, "_beats"}, beat, int'(len) + 1);
    chk({tag, "_ram_bad"}, bad, 0);
    chk({tag, "_busy_end"}, busy, 0);
    tick();
  endtask

  // Expects base+k on beat k; rd_ready held low for the first hold cycles.
  task automatic rd_burst(input logic [7:0] a, input logic [7:0] len, input int hold,
                          input logic [63:0] base, input string tag);
    int n = 0, iss = 0, c = 0, bad = 0, f_iss = -1, f_vld = -1, l_vld = -1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
    while (c < 1000) begin
      rd_ready = (c >= hold);
      #2;
      if (!busy) break;
      if (ram_cen && !ram_wen) begin
        iss++;
        if (f_iss < 0) f_iss = c;
      end
      if (hold > 0 && (c == 2 || c == hold - 1)) begin
        chk({tag, "_bp_issues"}, iss, 2);
        chk({tag, "_bp_valid"}, rd_valid, 1);
        chk({tag, "_bp_head"}, rd_data, base);
      end
      if (rd_valid && rd_ready) begin
        if (rd_data !== base + 64'(n)) bad++;
        if (f_vld < 0) f_vld = c;
        l_vld = c;
        n++;
      end
      c++;
      tick();
    end
    chk({tag, "_done"}, (c < 1000), 1);
    chk({tag, "_beats"}, n, int'(len) + 1);
    chk({tag, "_data_bad"}, bad, 0);
    chk({tag, "_issues"}, iss, int'(len) + 1);
    if (hold == 0) begin
      chk({tag, "_latency"}, f_vld - f_iss, 1);
      chk({tag, "_stream"}, l_vld - f_vld, int'(len));
    end
    rd_ready = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_ram_cen", ram_cen, 0);
    chk("rst_ram_wen", ram_wen, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    reset_n = 1'b1;
    tick();

    wr_burst(8'h01, 8'd0, 64'h0000_0000_0000_ffff, 1'b0, 1'b0, "w1");
    rd_burst(8'h01, 8'd0, 0, 64'h0000_0000_0000_ffff, "r1");

    wr_burst(8'hFE, 8'd3, 64'hA0, 1'b0, 1'b0, "wwrap");
    chk("wwrap_mem_00", mem[8'h00], 64'hA2);
    rd_burst(8'hFE, 8'd3, 0, 64'hA0, "rwrap");

    wr_burst(8'h10, 8'd7, 64'hB0, 1'b0, 1'b0, "w8");
    rd_burst(8'h10, 8'd7, 10, 64'hB0, "rbp");

    wr_burst(8'h20, 8'd3, 64'hC0, 1'b1, 1'b0, "wstall");
    rd_burst(8'h20, 8'd3, 0, 64'hC0, "rstall");

    wr_burst(8'h30, 8'd3, 64'hD0, 1'b0, 1'b1, "wpoke");
    chk("wpoke_mem_99", mem[8'h99] === 64'hD0 || mem[8'h99] === 64'hD1, 0);
    rd_burst(8'h30, 8'd3, 0, 64'hD0, "rpoke");

    // Abort a len-7 read during its third beat.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_len = 8'd7;
    tick();
    cmd_valid = 1'b0; rd_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    #2;
    chk("mrst_rd_valid", rd_valid, 0);
    chk("mrst_ram_cen", ram_cen, 0);
    chk("mrst_busy", busy, 0);
    tick();
    rd_ready = 1'b0;
    reset_n = 1'b1;
    tick();
    #2;
    chk("mrst_cmd_ready", cmd_ready, 1);
    chk("mrst_idle_cen", ram_cen, 0);
    tick();
    rd_burst(8'h10, 8'd1, 0, 64'hB0, "rrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
- Command-driven front end sitting directly upstream of the 256x64 single-port ram: it is the only driver of the ram's cen/wen/addr/din and the only consumer of its dout.
- Converts burst read/write commands (start address, beat count) into one ram access per cycle.
- Streams write data in and read data out over valid/ready handshakes with full backpressure.
- Absorbs the ram's read latency in a small output FIFO so no read beat is ever lost.

Parameters:
- AW, 8, ram address width
- DW, 64, data width
- RD_LAT, 1, cycles from the clk edge sampling a read (cen=1, wen=0) to valid ram_dout
- FIFO_DEPTH, 2, read-return buffer depth; must be >= RD_LAT+1

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high in IDLE only
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  AW  burst start address
- cmd_len  in  8  beats minus one (0 -> 1 beat, 255 -> 256 beats)
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted this cycle
- wr_data  in  DW  write beat
- rd_valid  out  1  read beat available
- rd_ready  in  1  consumer accepts read beat
- rd_data  out  DW  read beat (FIFO head)
- busy  out  1  high whenever state != IDLE
- ram_cen  out  1  ram chip enable, active high
- ram_wen  out  1  ram write enable (1=write, 0=read)
- ram_addr  out  AW  ram address
- ram_din  out  DW  ram write data
- ram_dout  in  DW  ram read data

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; outputs busy, rd_valid, wr_ready, ram_cen and ram_wen are 0; ram_addr and ram_din are 0; FIFO is emptied and the in-flight tracker is cleared. Any burst in progress is abandoned with no further ram access.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr, len and write. Go to WRITE or READ on the next edge.
  - WRITE: wr_ready=1. Each cycle with wr_valid&wr_ready, drive ram_cen=1, ram_wen=1, ram_addr=cur, ram_din=wr_data combinationally (ram samples same edge). Then cur+=1 and remaining-=1. After the last beat, go to IDLE.
  - READ: issue ram_cen=1, ram_wen=0, ram_addr=cur when (fifo_count + inflight) < FIFO_DEPTH and beats remain. After the last issue, go to DRAIN.
  - DRAIN: no ram access. Go to IDLE once inflight=0 and FIFO is empty (last beat handshaked).
- Read return: the in-flight shift register (RD_LAT stages) pushes ram_dout into the FIFO exactly RD_LAT cycles after issue. Push and pop in the same cycle are legal; count is unchanged.
- Address wrap: cur increments modulo 2^AW (8'hFF -> 8'h00).
- ram_cen=0 in every cycle without an access. ram_wen is don't-care when cen=0 but is driven 0.
- Throughput:
  - Write: 1 beat/cycle with continuous wr_valid.
  - Read: 1 beat/cycle with rd_ready held high; first rd_valid appears RD_LAT cycles after the first issue.
- Backpressure: with rd_ready=0, issue stops when the FIFO plus in-flight count reaches FIFO_DEPTH. No overflow and no data loss.
- cmd_valid outside IDLE is ignored (cmd_ready=0). A new command is accepted only in IDLE, i.e. at least one cycle after the previous burst completes.
- wr_valid outside WRITE is ignored.

Decomposition:
- Package ram_ctrl_pkg:
  - state enum (IDLE, WRITE, READ, DRAIN), 2 bits
  - AW/DW defaults
  - command struct {write, addr, len}
- Sub-module ctrl_rd_fifo: synchronous FIFO, parameters DW and FIFO_DEPTH; ports push, pop, din, dout, count, empty, full.

Test Plan:
- Single write then read: cmd write addr 8'h01 len 0, wr_data 64'h0000_0000_0000_ffff -> one cycle cen=1, wen=1, addr=1. Then cmd read addr 1 len 0 -> rd_data=64'h...ffff, 1 beat, busy drops after the handshake.
- Burst write/read with wrap: write addr 8'hFE len 3, data 0xA0..0xA3 -> ram addresses FE, FF, 00, 01. Read-back returns 0xA0..0xA3 in order.
- Backpressure: read len 7 with rd_ready=0 for 10 cycles -> at most FIFO_DEPTH issues, rd_data=first beat held stable. Release -> all 8 beats delivered in order, none duplicated.
- Write stalls: write len 3 with wr_valid toggling 1,0,1,0,... -> ram_cen=1 only on handshake cycles, 4 accesses total.
- Reset mid-burst: assert reset_n=0 during beat 2 of a len 7 read -> immediately rd_valid=0, ram_cen=0, busy=0, cmd_ready=1 after release. A subsequent read returns correct data.
- Command ignored while busy: pulse cmd_valid during a write burst -> no effect, cmd_ready=0, burst completes unchanged.
